// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_mp -- multi-read-port general-purpose register file
//
// Register 0 is hard-wired to zero. A write to it is rejected and flagged on
// err_zero. A clear sequencer walks r1..r(DEPTH-1) and zeroes one register
// per clock edge. While that sweep runs, writes are dropped and flagged on
// wr_drop.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When it is defined, a write that the array will accept this cycle is
//   forwarded combinationally to every read port addressing the same
//   register.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (zeroes array, aborts any sweep)
//   we        write enable
//   waddr     write address
//   wdata     write data
//   raddr     packed read addresses, port k = raddr[k*AW +: AW]
//   rdata     packed read data,      port k = rdata[k*DATA_WIDTH +: DATA_WIDTH]
//   clr_req   start a clear sweep (level, sampled each edge while idle)
//   clr_busy  clear sweep in progress
//   err_zero  one-cycle pulse: write to address 0 attempted
//   wr_drop   one-cycle pulse: write discarded because a sweep was running
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]         raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         err_zero,
    output logic                         wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         idx, idx_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic waddr_zero;
    logic wr_accept;
    logic err_zero_nxt;
    logic wr_drop_nxt;

    assign waddr_zero = (waddr == '0);
    assign wr_accept  = we && !waddr_zero && (state == IDLE);

    // A dropped write that also targets r0 reports only err_zero.
    assign err_zero_nxt = we && waddr_zero;
    assign wr_drop_nxt  = we && !waddr_zero && (state == CLEAR);

    assign clr_busy = (state == CLEAR);

    // Clear sequencer: the state register and the sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = AW'(1);  // r0 is already zero, so the sweep starts at r1
                end
            end
            CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt   = idx + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Error and drop flags: registered, so each pulse lasts one cycle per offending edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_zero <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            err_zero <= err_zero_nxt;
            wr_drop  <= wr_drop_nxt;
        end
    end

    // Storage. Accepted writes happen only in IDLE and sweep writes happen
    // only in CLEAR, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[waddr] <= wdata;
        end else if (state == CLEAR) begin
            mem[idx] <= '0;
        end
    end

    // Combinational read ports. Address 0 always reads zero.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (raddr[k*AW +: AW] != '0) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[k*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            // wr_accept already excludes r0 and writes dropped during a sweep.
            if (wr_accept && (raddr[k*AW +: AW] == waddr)) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
            end
`endif
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port general-purpose register file for the MIPS pipeline datapath. It sits between decode (read ports) and writeback (write port).
- Register 0 is hard-wired to zero; writes to it are rejected and flagged.
- An optional same-cycle write-to-read bypass can be compiled in.
- A hardware clear sequencer zeroes the whole file on request without a reset.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register
- DEPTH, 32, number of registers (power of two, ≥4)
- NUM_RD, 2, number of independent read ports
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  DATA_WIDTH  write data
- raddr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NUM_RD*DATA_WIDTH  packed read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- clr_req  in  1  start a clear sweep (level sampled each edge)
- clr_busy  out  1  clear sweep in progress
- err_zero  out  1  one-cycle pulse: a write to address 0 was attempted
- wr_drop  out  1  one-cycle pulse: a write was discarded because a sweep was in progress

## Operation
Reads:
- Combinational from the array.
- raddr==0 always returns 0.

Writes:
- On a rising edge with we=1, waddr≠0 and state IDLE, the array is updated: reg[waddr] <= wdata.
- A write with waddr==0 does not update the array and sets err_zero=1 for the next cycle.
- A write while state is CLEAR does not update the array and sets wr_drop=1 for the next cycle. If the dropped write also has waddr==0, only err_zero pulses.

Clear FSM, with state register and index register idx (AW bits):
- IDLE: when clr_req=1 at an edge, go to CLEAR with idx=1. A write presented at that same edge is still accepted.
- CLEAR: each edge zeroes reg[idx] and increments idx. On the edge that clears idx==DEPTH-1, go to IDLE. clr_req is ignored while in CLEAR.
- clr_busy is 1 exactly when state==CLEAR.
- Reads during CLEAR return the current array contents, a partially cleared mix.

Reset:
- rst_n=0 asynchronously zeroes all registers, sets state=IDLE and idx=0, and drives clr_busy, err_zero and wr_drop to 0.
- Reset asserted mid-sweep aborts the sweep. No resumption after reset.

## Timing
- Write latency: data written at edge T is visible on rdata after T, i.e. in cycle T+1, combinationally.
- Read latency: zero cycles. rdata follows raddr within the same cycle.
- Clear: clr_req sampled at edge T gives clr_busy=1 during cycles T+1 … T+DEPTH-1, which is DEPTH-1 cycles. clr_busy is 0 after edge T+DEPTH-1, and all registers read 0 from then on.
- err_zero and wr_drop are registered and last one cycle per offending edge. Back-to-back offending writes hold the pulse high continuously.
- Multiple read ports reading the same address are legal and return identical data.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If we=1 and state IDLE and waddr≠0 in the current cycle, any read port with raddr==waddr returns wdata combinationally in that same cycle.
  - There is no bypass for address 0, or for writes that will be dropped during CLEAR.
- REGFILE_BYPASS_EN undefined: reads return only the array contents, so new data appears the cycle after the write edge. The pipeline must then stall or forward externally.

## Test plan
- Reset then read all: hold rst_n=0 then release; every raddr 0..31 on both ports returns 0, and clr_busy/err_zero/wr_drop are 0.
- Write/readback: write 0xDEADBEEF to r5 and 0x12345678 to r31. Next cycle, port0=r5 and port1=r31 return those values, and r0 still reads 0.
- Zero-register guard: we=1, waddr=0, wdata=0xFFFFFFFF. Next cycle err_zero=1 for one cycle, and r0 reads 0.
- Bypass (REGFILE_BYPASS_EN on): write 0xA5A5A5A5 to r7 while port1 raddr=7; port1 shows 0xA5A5A5A5 in the same cycle. With the macro off, it shows the old value until the next cycle.
- Clear sweep: fill r1..r31 with nonzero values and pulse clr_req.
  - clr_busy is high for exactly 31 cycles.
  - A write to r9 mid-sweep produces wr_drop=1 and is not stored.
  - After the sweep, all registers read 0.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10. clr_busy drops immediately; after release all registers read 0 and state is IDLE, so a new clr_req restarts a full 31-cycle sweep.
